// File: rtl/aq_local_arb.sv
// Two-requester round-robin arbiter for a shared AQ_LOCAL register target.
// It forwards one registered transaction at a time and forces completion with TIMEOUT_DATA if the target never answers.
module aq_local_arb #(
    parameter int          TIMEOUT      = 256,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD
) (
    input  logic        AQ_LOCAL_CLK,
    input  logic        RST,
    input  logic        M0_CS,
    input  logic        M0_RNW,
    input  logic [15:0] M0_ADDR,
    input  logic [3:0]  M0_BE,
    input  logic [31:0] M0_WDATA,
    output logic        M0_ACK,
    output logic [31:0] M0_RDATA,
    input  logic        M1_CS,
    input  logic        M1_RNW,
    input  logic [15:0] M1_ADDR,
    input  logic [3:0]  M1_BE,
    input  logic [31:0] M1_WDATA,
    output logic        M1_ACK,
    output logic [31:0] M1_RDATA,
    output logic        AQ_LOCAL_CS,
    output logic        AQ_LOCAL_RNW,
    output logic [15:0] AQ_LOCAL_ADDR,
    output logic [3:0]  AQ_LOCAL_BE,
    output logic [31:0] AQ_LOCAL_WDATA,
    input  logic        AQ_LOCAL_ACK,
    input  logic [31:0] AQ_LOCAL_RDATA,
    input  logic        ERR_CLR,
    output logic        ERR,
    output logic        ERR_ID,
    output logic        BUSY
);

    localparam int            TW     = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          last_grant;
    logic          winner;
    logic          complete;
    logic [31:0]   done_data;

    // On a tie the requester that was not served last takes the bus.
    assign winner = (M0_CS && M1_CS) ? ~last_grant : M1_CS;

    // A target ACK on the final timer cycle still counts as a real completion.
    assign complete  = AQ_LOCAL_ACK || (timer == T_LAST);
    assign done_data = AQ_LOCAL_ACK ? AQ_LOCAL_RDATA : TIMEOUT_DATA;

    always_ff @(posedge AQ_LOCAL_CLK) begin
        if (RST) begin
            state          <= ST_IDLE;
            timer          <= '0;
            last_grant     <= 1'b1;
            AQ_LOCAL_CS    <= 1'b0;
            AQ_LOCAL_RNW   <= 1'b1;
            AQ_LOCAL_ADDR  <= '0;
            AQ_LOCAL_BE    <= '0;
            AQ_LOCAL_WDATA <= '0;
            M0_ACK         <= 1'b0;
            M1_ACK         <= 1'b0;
            M0_RDATA       <= '0;
            M1_RDATA       <= '0;
            ERR            <= 1'b0;
            ERR_ID         <= 1'b0;
            BUSY           <= 1'b0;
        end else begin
            M0_ACK <= 1'b0;
            M1_ACK <= 1'b0;
            // A timeout later in this block overrides the clear.
            if (ERR_CLR) begin
                ERR    <= 1'b0;
                ERR_ID <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (M0_CS || M1_CS) begin
                        state          <= ST_BUSY;
                        BUSY           <= 1'b1;
                        timer          <= '0;
                        last_grant     <= winner;
                        AQ_LOCAL_CS    <= 1'b1;
                        AQ_LOCAL_RNW   <= winner ? M1_RNW   : M0_RNW;
                        AQ_LOCAL_ADDR  <= winner ? M1_ADDR  : M0_ADDR;
                        AQ_LOCAL_BE    <= winner ? M1_BE    : M0_BE;
                        AQ_LOCAL_WDATA <= winner ? M1_WDATA : M0_WDATA;
                    end
                end
                ST_BUSY: begin
                    if (complete) begin
                        state       <= ST_DONE;
                        AQ_LOCAL_CS <= 1'b0;
                        if (last_grant) begin
                            M1_ACK   <= 1'b1;
                            M1_RDATA <= done_data;
                        end else begin
                            M0_ACK   <= 1'b1;
                            M0_RDATA <= done_data;
                        end
                        if (!AQ_LOCAL_ACK) begin
                            ERR    <= 1'b1;
                            ERR_ID <= last_grant;
                        end
                    end else if (timer != T_SAT) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    BUSY        <= 1'b0;
                    AQ_LOCAL_CS <= 1'b0;
                end
            endcase
        end
    end

endmodule
